mux2to1_stream_arbiter: RTL and testbench

- Upstream control-and-buffer stage for the team's 2:1 data mux.
- Arbitrates between two valid/ready input streams and generates the select (`sel`) that steers the 2:1 mux.
- Registers the selected word into a single-entry output stage.
- Round-robin arbitration with a bounded burst: the current owner keeps the grant for at most BURST_MAX consecutive transfers while the other input is waiting.

---
 rtl/mux2to1_pkg.sv | 14 +
 rtl/stream_out_reg.sv | 27 ++
 rtl/mux2to1_stream_arbiter.sv | 89 ++++++++
 tb/tb_mux2to1_stream_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux2to1_pkg.sv
// Shared constants and helpers for the 2:1 stream arbiter.
package mux2to1_pkg;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  localparam int unsigned WIDTH_DEF = 8;

  // Counter width able to hold 0..burst_max inclusive.
  function automatic int unsigned cnt_width(input int unsigned burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register: load, hold under backpressure, drain.
module stream_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Load on push, clear valid once drained with nothing new, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (push) begin
      out_valid <= 1'b1;
      out_data  <= push_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux2to1_stream_arbiter.sv
// Round-robin 2:1 stream arbiter with bounded bursts feeding a registered output stage.
module mux2to1_stream_arbiter
  import mux2to1_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CW = cnt_width(BURST_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic             owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             own_valid, oth_valid;
  logic             sel_valid, load, xfer;
  logic [WIDTH-1:0] sel_data;

  // Grant selection: owner keeps the grant until its burst limit while the other waits.
  always_comb begin
    own_valid = owner_q ? in1_valid : in0_valid;
    oth_valid = owner_q ? in0_valid : in1_valid;
    sel       = owner_q;
    if (!rst) begin
      if (own_valid && ((cnt_q < CNT_MAX) || !oth_valid)) begin
        sel = owner_q;
      end else if (oth_valid) begin
        sel = ~owner_q;
      end
    end
    sel_valid = sel ? in1_valid : in0_valid;
    sel_data  = sel ? in1_data : in0_data;
    load      = !out_valid || out_ready;
    in0_ready = !rst && load && (sel == SEL_IN0);
    in1_ready = !rst && load && (sel == SEL_IN1);
    xfer      = !rst && sel_valid && load;
  end

  // Burst bookkeeping: count repeat grants (saturating), restart at 1 on a switch.
  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      if (sel == owner_q) begin
        cnt_d = (cnt_q >= CNT_MAX) ? cnt_q : CW'(cnt_q + CNT_ONE);
      end else begin
        owner_d = sel;
        cnt_d   = CNT_ONE;
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= SEL_IN0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  stream_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .push      (xfer),
    .push_data (sel_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_mux2to1_stream_arbiter.sv
// Randomized and directed bench for mux2to1_stream_arbiter against a behavioural model.
module tb_mux2to1_stream_arbiter;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned BURST_MAX = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in0_data, in1_data, out_data;
  logic             in0_valid, in1_valid, in0_ready, in1_ready;
  logic             sel, out_valid, out_ready;

  always #5 clk = ~clk;

  mux2to1_stream_arbiter #(
    .WIDTH     (WIDTH),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int tests  = 0;
  int errors = 0;

  // Reference model: who owns the grant, how many words it has sent, and the output slot.
  int         m_owner;
  int         m_cnt;
  bit         m_ov;
  logic [7:0] m_od;

  // Observations from the most recent step (sampled at the falling edge).
  logic [7:0] obs_data;
  logic       obs_valid, obs_sel, obs_r0, obs_r1;
  bit         acc0, acc1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_cnt   = 0;
    m_ov    = 1'b0;
    m_od    = 8'h00;
  endtask

  // One clock cycle: drive, compare everything against the model, advance the model.
  task automatic step(input logic v0, input logic [7:0] d0, input logic v1,
                      input logic [7:0] d1, input logic ordy, input logic r);
    int es;
    bit want_own, want_oth, ld;
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = ordy;
    rst       = r;
    @(negedge clk);
    want_own = (m_owner == 1) ? v1 : v0;
    want_oth = (m_owner == 1) ? v0 : v1;
    if (r)                                              es = m_owner;
    else if (want_own && (m_cnt < int'(BURST_MAX) || !want_oth)) es = m_owner;
    else if (want_oth)                                  es = 1 - m_owner;
    else                                                es = m_owner;
    ld = !m_ov || ordy;
    acc0 = !r && ld && (es == 0) && v0;
    acc1 = !r && ld && (es == 1) && v1;
    obs_data  = out_data;
    obs_valid = out_valid;
    obs_sel   = sel;
    obs_r0    = in0_ready;
    obs_r1    = in1_ready;
    check("sel",       32'(sel),         32'(es));
    check("in0_ready", 32'(in0_ready),   32'(!r && ld && es == 0));
    check("in1_ready", 32'(in1_ready),   32'(!r && ld && es == 1));
    check("out_valid", 32'(out_valid),   32'(m_ov));
    check("out_data",  32'(out_data),    32'(m_od));
    check("owner_q",   32'(dut.owner_q), 32'(m_owner));
    check("cnt_q",     32'(dut.cnt_q),   32'(m_cnt));
    if (r) begin
      model_reset();
    end else if (acc0 || acc1) begin
      m_od = (es == 1) ? d1 : d0;
      m_ov = 1'b1;
      if (es == m_owner) begin
        m_cnt = (m_cnt + 1 > int'(BURST_MAX)) ? int'(BURST_MAX) : m_cnt + 1;
      end else begin
        m_owner = es;
        m_cnt   = 1;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  logic [7:0] exp_order [8];
  logic [7:0] n0, n1, rd0, rd1;
  logic       rv0, rv1;

  initial begin
    rst       = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    do_reset();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check("rst_out_valid", 32'(obs_valid), 32'd0);
    check("rst_sel",       32'(obs_sel),   32'd0);

    // Single requester on in0
    step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_r1_a", 32'(obs_r1), 32'd0);
    step(1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_d11", 32'(obs_data), 32'h11);
    check("t1_r1_b", 32'(obs_r1), 32'd0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_d22", 32'(obs_data), 32'h22);
    check("t1_v22", 32'(obs_valid), 32'd1);

    // Contention, bounded bursts
    do_reset();
    exp_order[0] = 8'hA0; exp_order[1] = 8'hA1; exp_order[2] = 8'hB0; exp_order[3] = 8'hB1;
    exp_order[4] = 8'hA2; exp_order[5] = 8'hA3; exp_order[6] = 8'hB2; exp_order[7] = 8'hB3;
    n0 = 8'hA0;
    n1 = 8'hB0;
    for (int k = 0; k < 9; k++) begin
      step(1'b1, n0, 1'b1, n1, 1'b1, 1'b0);
      if (k > 0) begin
        check("t2_valid", 32'(obs_valid), 32'd1);
        check("t2_order", 32'(obs_data),  32'(exp_order[k-1]));
      end
      if (acc0) n0 = n0 + 8'd1;
      if (acc1) n1 = n1 + 8'd1;
    end

    // Backpressure with both inputs waiting
    do_reset();
    step(1'b1, 8'h5C, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h61, 1'b1, 8'h71, 1'b0, 1'b0);
      check("t3_hold", 32'(obs_data), 32'h5C);
      check("t3_r0",   32'(obs_r0),   32'd0);
      check("t3_r1",   32'(obs_r1),   32'd0);
    end
    step(1'b1, 8'h61, 1'b1, 8'h71, 1'b1, 1'b0);
    check("t3_drain", 32'(obs_data), 32'h5C);
    check("t3_r0_up", 32'(obs_r0),   32'd1);
    step(1'b0, 8'h00, 1'b1, 8'h71, 1'b1, 1'b0);
    check("t3_next", 32'(obs_data), 32'h61);

    // Lone requester on in1 past the burst limit
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 8'h00, (k < 6), 8'(8'hC0 + k), 1'b1, 1'b0);
      if (k < 6) check("t4_sel", 32'(obs_sel), 32'd1);
      if (k > 0) check("t4_data", 32'(obs_data), 32'(8'hC0 + k - 1));
    end
    check("t4_sat", 32'(dut.cnt_q), 32'(BURST_MAX));

    // Reset mid-operation with in1 owning and output full
    step(1'b0, 8'h00, 1'b1, 8'hD0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'hD1, 1'b0, 1'b1);
    check("t5_r0", 32'(obs_r0), 32'd0);
    check("t5_r1", 32'(obs_r1), 32'd0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t5_valid", 32'(obs_valid), 32'd0);
    check("t5_data",  32'(obs_data),  32'd0);
    check("t5_sel",   32'(obs_sel),   32'd0);

    // Switch on limit
    do_reset();
    step(1'b1, 8'h31, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h32, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b1, 8'h41, 1'b1, 1'b0);
    check("t6_sel", 32'(obs_sel), 32'd1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_data",  32'(obs_data),    32'h41);
    check("t6_owner", 32'(dut.owner_q), 32'd1);
    check("t6_cnt",   32'(dut.cnt_q),   32'd1);

    // Randomized traffic; a pending word is held until it is accepted
    rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (!rv0 || acc0) begin
        rv0 = 1'($urandom_range(0, 1));
        rd0 = 8'($urandom);
      end
      if (!rv1 || acc1) begin
        rv1 = 1'($urandom_range(0, 1));
        rd1 = 8'($urandom);
      end
      step(rv0, rd0, rv1, rd1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
